mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 12 bits, matching the 4096-word RAM; data width fixed at 16 bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU (MAR/MDR side) access request, held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-006 cpu_addr  input  12  CPU word address; stable while cpu_req high.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_rdata  output  16  last read data returned to CPU.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 ld_req, ld_we, ld_addr[11:0], ld_wdata[15:0]  inputs  loader/debug port, same meaning as the CPU equivalents.
REQ-011 ld_rdata  output  16; ld_ack  output  1  loader equivalents of cpu_rdata and cpu_ack.
REQ-012 ld_lock  input  1  while high, no new CPU grant is issued.
REQ-013 ram_r_en, ram_w_en  output  1 each  RAM read/write enables.
REQ-014 ram_r_addr, ram_w_addr  output  12 each  RAM addresses, always equal.
REQ-015 ram_w_data  output  16  RAM write data; ram_r_data  input  16  RAM synchronous read data, valid the cycle after ram_r_en.
REQ-016 busy  output  1  high whenever FSM is not IDLE; owner  output  1  0 = CPU, 1 = loader, the current/last grantee.

Function
REQ-017 FSM states IDLE, ISSUE, CAPTURE, ACK; each non-IDLE state lasts exactly one cycle: IDLE->ISSUE (on grant), ISSUE->CAPTURE, CAPTURE->ACK, ACK->IDLE.
REQ-018 Arbitration occurs only in IDLE; requests arriving while busy wait, untouched, until IDLE.
REQ-019 Eligible requesters: ld_req; cpu_req only when ld_lock = 0.
REQ-020 One eligible requester: grant it; both eligible: grant the one not served last (round-robin via owner).
REQ-021 On grant, latch the grantee's we, addr and wdata into internal registers; set owner.
REQ-022 ISSUE: drive latched addr on ram_r_addr and ram_w_addr; drive ram_w_en = we, ram_r_en = ~we; ram_w_data = latched wdata.
REQ-023 Enables are 0 in every state other than ISSUE; exactly one enable pulse per granted transaction.
REQ-024 CAPTURE: for reads, register ram_r_data into the grantee's rdata output; the other port's rdata is unchanged; writes leave both rdata outputs unchanged.
REQ-025 ACK: assert the grantee's ack for exactly one cycle; the other ack stays 0.
REQ-026 Latency: req sampled in IDLE at edge N -> ram enable during cycle N+1 -> ack high during cycle N+3; next grant no earlier than edge N+4.
REQ-027 A requester drops req on the edge ending its ack cycle; req still high in the following IDLE is a new request.
REQ-028 ld_lock rising mid-transaction does not abort a CPU transaction in progress.
REQ-029 rdata outputs hold their value indefinitely between reads.

Reset
REQ-030 reset high asynchronously forces state IDLE, ram_r_en = ram_w_en = 0, cpu_ack = ld_ack = 0, cpu_rdata = ld_rdata = 0, busy = 0, owner = 1 (CPU wins first tie); latched addr/wdata cleared to 0.
REQ-031 Reset during ISSUE, CAPTURE or ACK abandons the transaction with no ack; a write already issued may have completed in RAM.
REQ-032 First arbitration occurs in the first IDLE cycle after reset deasserts.

Verification
REQ-033 Reset, then CPU read addr 0x005 with RAM word 0x1234 -> ram_r_en one cycle after grant, cpu_ack 3 cycles after grant edge, cpu_rdata = 0x1234, ld_rdata = 0.
REQ-034 Loader write 0xBEEF to 0xFFF, then CPU read 0xFFF -> exactly one ram_w_en pulse with ram_w_addr = 0xFFF; cpu_rdata = 0xBEEF.
REQ-035 cpu_req and ld_req raised in the same cycle, both held for two transactions -> order CPU, loader, CPU, loader, each with its own ack only.
REQ-036 ld_lock = 1 with both requesting -> only loader served, cpu_ack stays 0; drop ld_lock -> CPU served next IDLE.
REQ-037 reset asserted during CAPTURE of a loader read -> no ld_ack, all outputs at reset values immediately (asynchronous), busy = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single 4096 x 16 synchronous RAM. A CPU port
// and a loader/debug port each issue single-word read or write requests; the
// arbiter serialises them through a four-state FSM
// (IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE), so every transaction occupies
// the RAM for exactly one enable cycle and completes with a one-cycle ack.
//
// Arbitration happens only in IDLE. The loader is always eligible; the CPU is
// eligible only while ld_lock is low. On a tie the port that was not served
// last wins (round-robin on the owner flag).
//
// Ports
//   clk, reset               clock (rising edge) and async active-high reset
//   cpu_req/we/addr/wdata    CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack       CPU read data (held between reads) / done pulse
//   ld_req/we/addr/wdata     loader request (held until ld_ack)
//   ld_rdata, ld_ack         loader read data / done pulse
//   ld_lock                  blocks new CPU grants while high
//   ram_r_en, ram_w_en       RAM enables, high only in ISSUE
//   ram_r_addr, ram_w_addr   RAM address (both always equal)
//   ram_w_data, ram_r_data   RAM write data / read data (valid cycle after r_en)
//   busy                     FSM not in IDLE
//   owner                    current/last grantee: 0 = CPU, 1 = loader
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,

    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [11:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic [15:0] ld_rdata,
    output logic        ld_ack,
    input  logic        ld_lock,

    output logic        ram_r_en,
    output logic        ram_w_en,
    output logic [11:0] ram_r_addr,
    output logic [11:0] ram_w_addr,
    output logic [15:0] ram_w_data,
    input  logic [15:0] ram_r_data,

    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic        owner_q,     owner_d;
    logic        we_q,        we_d;
    logic [11:0] addr_q,      addr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ld_rdata_q,  ld_rdata_d;

    logic cpu_elig;
    logic ld_elig;
    logic grant_ld;

    // Eligibility and round-robin choice. With both eligible, owner_q = 0
    // means the CPU was served last, so the loader takes this turn.
    always_comb begin
        cpu_elig = cpu_req & ~ld_lock;
        ld_elig  = ld_req;
        grant_ld = ld_elig & (~cpu_elig | ~owner_q);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_elig | ld_elig) begin
                    state_d = ST_ISSUE;
                    owner_d = grant_ld;
                    if (grant_ld) begin
                        we_d    = ld_we;
                        addr_d  = ld_addr;
                        wdata_d = ld_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end

            // RAM read data is valid during this cycle (one after the enable).
            ST_CAPTURE: begin
                state_d = ST_ACK;
                if (!we_q) begin
                    if (owner_q) begin
                        ld_rdata_d = ram_r_data;
                    end else begin
                        cpu_rdata_d = ram_r_data;
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // owner resets to the loader so the CPU wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= 12'h000;
            wdata_q     <= 16'h0000;
            cpu_rdata_q <= 16'h0000;
            ld_rdata_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // Outputs decode directly from registered state, so the asynchronous
    // reset drives every one of them to its idle value immediately.
    always_comb begin
        ram_r_en   = (state_q == ST_ISSUE) & ~we_q;
        ram_w_en   = (state_q == ST_ISSUE) &  we_q;
        ram_r_addr = addr_q;
        ram_w_addr = addr_q;
        ram_w_data = wdata_q;

        cpu_ack    = (state_q == ST_ACK) & ~owner_q;
        ld_ack     = (state_q == ST_ACK) &  owner_q;
        cpu_rdata  = cpu_rdata_q;
        ld_rdata   = ld_rdata_q;

        busy       = (state_q != ST_IDLE);
        owner      = owner_q;
    end

endmodule
